// File: rtl/pool_sched_if.sv
// Bundle of the instruction, dispatch, arbitration and memory-return signals of pool_sched.
// master is the scheduler side; slave is the front end / processor pool side.
interface pool_sched_if #(
    parameter int NPROC   = 4,
    parameter int INSTR_W = 64,
    parameter int ID_W    = 2
);
    logic               i_instr_valid;
    logic [INSTR_W-1:0] i_instr;
    logic               o_instr_ready;
    logic [INSTR_W-1:0] o_proc_instr;
    logic [NPROC-1:0]   o_proc_en;
    logic [NPROC-1:0]   i_proc_ack;
    logic [NPROC-1:0]   i_proc_busy;
    logic [NPROC-1:0]   i_proc_finish;
    logic [NPROC-1:0]   i_proc_req;
    logic [NPROC-1:0]   o_proc_grant;
    logic               i_mem_valid;
    logic [NPROC-1:0]   o_proc_valid;
    logic [ID_W-1:0]    o_grant_id;
    logic               o_all_idle;
    logic               o_err;

    modport master (
        input  i_instr_valid, i_instr, i_proc_ack, i_proc_busy, i_proc_finish,
               i_proc_req, i_mem_valid,
        output o_instr_ready, o_proc_instr, o_proc_en, o_proc_grant, o_proc_valid,
               o_grant_id, o_all_idle, o_err
    );

    modport slave (
        output i_instr_valid, i_instr, i_proc_ack, i_proc_busy, i_proc_finish,
               i_proc_req, i_mem_valid,
        input  o_instr_ready, o_proc_instr, o_proc_en, o_proc_grant, o_proc_valid,
               o_grant_id, o_all_idle, o_err
    );
endinterface

// File: rtl/pool_sched.sv
// SIMD pool scheduler: dispatches instructions to the lowest free proc and round-robin
// arbitrates shared memory. Define POOL_SCHED_ACK_TMO_EN to enable the dispatch ack timeout.
module pool_sched #(
    parameter int NPROC   = 4,
    parameter int INSTR_W = 64,
    parameter int ID_W    = 2,
    parameter int ACK_TMO = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    pool_sched_if.master bus
);

`ifdef POOL_SCHED_ACK_TMO_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int TMO_W = $clog2(ACK_TMO) + 1;

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t             r_state, w_state_nxt;
    logic [INSTR_W-1:0] r_instr;
    logic [NPROC-1:0]   r_en, r_reserved, r_mask, r_grant;
    logic [ID_W-1:0]    r_target, r_grant_id, r_ptr;
    logic               r_err, r_pending;
    logic [TMO_W-1:0]   r_tmo_cnt;

    logic [NPROC-1:0]   w_free;
    logic               w_any_free, w_ack, w_tmo_hit, w_hold;
    logic [ID_W-1:0]    w_low_free, w_pick;
    logic               w_ready, w_load, w_dispatch, w_acked, w_timeout;

    function automatic logic [NPROC-1:0] onehot(input logic [ID_W-1:0] idx);
        logic [NPROC-1:0] v;
        for (int i = 0; i < NPROC; i++) v[i] = (int'(idx) == i);
        return v;
    endfunction

    function automatic logic [ID_W-1:0] lowest(input logic [NPROC-1:0] v);
        logic [ID_W-1:0] res;
        res = '0;
        for (int i = NPROC - 1; i >= 0; i--) if (v[i]) res = ID_W'(i);
        return res;
    endfunction

    // First requester at or after ptr, wrapping around the pool.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NPROC-1:0] req,
                                                input logic [ID_W-1:0] ptr);
        logic            found;
        logic [ID_W-1:0] res;
        int              idx;
        found = 1'b0;
        res   = ptr;
        for (int i = 0; i < NPROC; i++) begin
            idx = (int'(ptr) + i) % NPROC;
            if (!found && req[idx]) begin
                found = 1'b1;
                res   = ID_W'(idx);
            end
        end
        return res;
    endfunction

    assign w_free     = ~bus.i_proc_busy & ~r_reserved & ~r_mask;
    assign w_any_free = |w_free;
    assign w_low_free = lowest(w_free);
    // r_en is one-hot on the target while issuing, so this ignores acks from other procs.
    assign w_ack      = |(bus.i_proc_ack & r_en);
    assign w_tmo_hit  = TMO_EN && (r_state == S_ISSUE) && (r_tmo_cnt == TMO_W'(ACK_TMO - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_load      = 1'b0;
        w_dispatch  = 1'b0;
        w_acked     = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pending) begin
                    if (w_any_free) begin
                        w_dispatch  = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end
                end else begin
                    w_ready = w_any_free;
                    if (bus.i_instr_valid && w_any_free) begin
                        w_load      = 1'b1;
                        w_dispatch  = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (w_ack) begin
                    w_acked     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_instr    <= '0;
            r_en       <= '0;
            r_target   <= '0;
            r_reserved <= '0;
            r_mask     <= '0;
            r_err      <= 1'b0;
            r_pending  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) r_instr <= bus.i_instr;
            if (w_dispatch) begin
                r_en      <= onehot(w_low_free);
                r_target  <= w_low_free;
                r_pending <= 1'b0;
            end else if (w_acked || w_timeout) begin
                r_en <= '0;
            end
            if (w_timeout) begin
                r_mask    <= r_mask | onehot(r_target);
                r_err     <= 1'b1;
                r_pending <= 1'b1;
            end
            // A finish in the same cycle as the ack cannot clear the new reservation.
            r_reserved <= (r_reserved & ~bus.i_proc_finish) | (w_acked ? onehot(r_target) : '0);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tmo_cnt <= '0;
        end else if (TMO_EN && (r_state == S_ISSUE) && !w_ack && !w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    assign w_hold = |(r_grant & bus.i_proc_req);
    assign w_pick = rr_pick(bus.i_proc_req, r_ptr);

    // Owner keeps the grant while requesting; handover happens on the same edge it drops.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_grant    <= '0;
            r_grant_id <= '0;
            r_ptr      <= '0;
        end else if (!w_hold) begin
            if (|bus.i_proc_req) begin
                r_grant    <= onehot(w_pick);
                r_grant_id <= w_pick;
                r_ptr      <= ID_W'((int'(w_pick) + 1) % NPROC);
            end else begin
                r_grant <= '0;
            end
        end
    end

    assign bus.o_instr_ready = w_ready;
    assign bus.o_proc_instr  = r_instr;
    assign bus.o_proc_en     = r_en;
    assign bus.o_proc_grant  = r_grant;
    assign bus.o_proc_valid  = {NPROC{bus.i_mem_valid}} & r_grant;
    assign bus.o_grant_id    = r_grant_id;
    assign bus.o_all_idle    = (r_state == S_IDLE) && !(|bus.i_proc_busy) && !(|r_reserved);
    assign bus.o_err         = r_err;

endmodule

// File: tb/tb_pool_sched.sv
// Scoreboard bench for pool_sched: stimulus pushes expected dispatches and grant changes,
// monitors pop and compare them; direct checks cover ready, idle, reset and routing.
module tb_pool_sched;
    logic       clk;
    logic       rst;
    logic [3:0] ack_mask;
    int         n_chk;
    int         n_pass;

    typedef struct {
        logic [3:0]  en;
        logic [63:0] instr;
    } disp_t;

    disp_t      disp_q[$];
    logic [3:0] grant_q[$];

    pool_sched_if #(.NPROC(4), .INSTR_W(64), .ID_W(2)) bus ();

    pool_sched #(.NPROC(4), .INSTR_W(64), .ID_W(2), .ACK_TMO(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one instruction and returns just after the accepting edge.
    task automatic send(input logic [63:0] instr, input int idx, input bit expect_disp);
        disp_t d;
        bit    ok;
        if (expect_disp) begin
            d.en    = 4'b0001 << idx;
            d.instr = instr;
            disp_q.push_back(d);
        end
        bus.i_instr_valid = 1'b1;
        bus.i_instr       = instr;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (bus.o_instr_ready) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        if (!ok) check("send_timeout", 64'd0, 64'd1);
        tick(1);
        bus.i_instr_valid = 1'b0;
    endtask

    // Simple proc model: acks a dispatch in its first cycle if enabled by ack_mask.
    initial begin
        bus.i_proc_ack = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.i_proc_ack = bus.o_proc_en & ack_mask;
        end
    end

    initial begin : disp_mon
        disp_t d;
        forever begin
            @(negedge clk);
            if (!rst && (bus.o_proc_en & bus.i_proc_ack) != 4'b0000) begin
                if (disp_q.size() == 0) begin
                    check("disp_unexpected", {60'd0, bus.o_proc_en}, 64'd0);
                end else begin
                    d = disp_q.pop_front();
                    check("disp_en", {60'd0, bus.o_proc_en}, {60'd0, d.en});
                    check("disp_instr", bus.o_proc_instr, d.instr);
                end
            end
        end
    end

    initial begin : grant_mon
        logic [3:0] prev_g;
        logic [3:0] e;
        prev_g = 4'b0000;
        forever begin
            @(negedge clk);
            if (bus.o_proc_grant !== prev_g) begin
                if (grant_q.size() == 0) begin
                    check("grant_unexpected", {60'd0, bus.o_proc_grant}, {60'd0, prev_g});
                end else begin
                    e = grant_q.pop_front();
                    check("grant_seq", {60'd0, bus.o_proc_grant}, {60'd0, e});
                end
                prev_g = bus.o_proc_grant;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        ack_mask = 4'hF;
        rst = 1'b1;
        bus.i_instr_valid = 1'b0;
        bus.i_instr       = '0;
        bus.i_proc_busy   = '0;
        bus.i_proc_finish = '0;
        bus.i_proc_req    = '0;
        bus.i_mem_valid   = 1'b0;
        tick(2);
        check("rst_en", {60'd0, bus.o_proc_en}, 64'd0);
        check("rst_grant", {60'd0, bus.o_proc_grant}, 64'd0);
        check("rst_grant_id", {62'd0, bus.o_grant_id}, 64'd0);
        check("rst_instr", bus.o_proc_instr, 64'd0);
        check("rst_all_idle", {63'd0, bus.o_all_idle}, 64'd1);
        check("rst_err", {63'd0, bus.o_err}, 64'd0);
        check("rst_ready", {63'd0, bus.o_instr_ready}, 64'd1);
        rst = 1'b0;
        tick(1);

        // Fill the pool in index order.
        for (int i = 0; i < 4; i++) send(64'hA0 + 64'(i), i, 1'b1);
        tick(1);
        check("ready_full", {63'd0, bus.o_instr_ready}, 64'd0);
        check("busy_not_idle", {63'd0, bus.o_all_idle}, 64'd0);

        // Pending instruction waits until proc1 finishes.
        bus.i_instr_valid = 1'b1;
        bus.i_instr       = 64'hB5;
        tick(2);
        check("ready_blocked", {63'd0, bus.o_instr_ready}, 64'd0);
        bus.i_proc_finish = 4'b0010;
        check("ready_during_finish", {63'd0, bus.o_instr_ready}, 64'd0);
        tick(1);
        bus.i_proc_finish = 4'b0000;
        check("ready_after_finish", {63'd0, bus.o_instr_ready}, 64'd1);
        disp_q.push_back('{en: 4'b0010, instr: 64'hB5});
        tick(1);
        bus.i_instr_valid = 1'b0;
        bus.i_proc_finish = 4'b0010;
        tick(1);
        bus.i_proc_finish = 4'b0000;
        check("ack_wins_finish", {63'd0, bus.o_instr_ready}, 64'd0);
        bus.i_proc_finish = 4'b1111;
        tick(1);
        bus.i_proc_finish = 4'b0000;
        check("idle_after_finish", {63'd0, bus.o_all_idle}, 64'd1);
        check("ready_after_clear", {63'd0, bus.o_instr_ready}, 64'd1);

        // Round-robin handover 0 -> 1 -> 3 with no idle gap.
        grant_q.push_back(4'b0001);
        grant_q.push_back(4'b0010);
        grant_q.push_back(4'b1000);
        grant_q.push_back(4'b0000);
        bus.i_proc_req = 4'b1011;
        tick(1);
        check("gid_0", {62'd0, bus.o_grant_id}, 64'd0);
        tick(2);
        bus.i_proc_req = 4'b1010;
        tick(1);
        check("gid_1", {62'd0, bus.o_grant_id}, 64'd1);
        tick(2);
        bus.i_proc_req = 4'b1000;
        tick(1);
        check("gid_3", {62'd0, bus.o_grant_id}, 64'd3);
        tick(2);
        bus.i_proc_req = 4'b0000;
        tick(1);
        check("gid_held", {62'd0, bus.o_grant_id}, 64'd3);

        // Memory data routed to the granted proc only.
        grant_q.push_back(4'b0100);
        grant_q.push_back(4'b0000);
        bus.i_proc_req = 4'b0100;
        tick(1);
        bus.i_mem_valid = 1'b1;
        #1;
        check("valid_route", {60'd0, bus.o_proc_valid}, 64'h4);
        check("gid_2", {62'd0, bus.o_grant_id}, 64'd2);
        bus.i_mem_valid = 1'b0;
        #1;
        check("valid_off", {60'd0, bus.o_proc_valid}, 64'd0);
        bus.i_proc_req = 4'b0000;
        tick(1);

`ifdef POOL_SCHED_ACK_TMO_EN
        begin
            int en_cyc;
            ack_mask = 4'b1110;
            send(64'hC0, 1, 1'b1);
            en_cyc = 0;
            for (int k = 0; k < 40; k++) begin
                if (bus.o_proc_en != 4'b0001) break;
                en_cyc++;
                tick(1);
            end
            check("tmo_en_cycles", 64'(en_cyc), 64'd16);
            check("tmo_err", {63'd0, bus.o_err}, 64'd1);
            check("tmo_ready_low", {63'd0, bus.o_instr_ready}, 64'd0);
            tick(3);
            bus.i_proc_finish = 4'b0010;
            tick(1);
            bus.i_proc_finish = 4'b0000;
            check("tmo_err_sticky", {63'd0, bus.o_err}, 64'd1);
            ack_mask = 4'hF;
        end
`endif

        // Reset while issuing with a grant held.
        ack_mask = 4'b0000;
        send(64'hD0, 0, 1'b0);
        grant_q.push_back(4'b0001);
        grant_q.push_back(4'b0000);
        bus.i_proc_req = 4'b0001;
        tick(2);
        rst = 1'b1;
        #1;
        check("mid_rst_en", {60'd0, bus.o_proc_en}, 64'd0);
        check("mid_rst_grant", {60'd0, bus.o_proc_grant}, 64'd0);
        check("mid_rst_idle", {63'd0, bus.o_all_idle}, 64'd1);
        check("mid_rst_err", {63'd0, bus.o_err}, 64'd0);
        bus.i_proc_req = 4'b0000;
        tick(1);
        rst = 1'b0;
        ack_mask = 4'hF;
        tick(1);
        send(64'hE0, 0, 1'b1);
        tick(3);

        check("disp_q_empty", 64'(disp_q.size()), 64'd0);
        check("grant_q_empty", 64'(grant_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
